// File: rtl/l2_cache_nway.sv
// Set-associative write-back/write-allocate L2 with tree-PLRU replacement; optional L2_PERF_COUNTERS_EN adds hit/miss counters.
// Latency: hit responds 1 cycle after the request cycle; a miss adds an optional writeback plus a fill, then re-checks.
// Backpressure: CPU holds the request until mem_resp; pmem_read/pmem_write are held until pmem_resp.
module l2_cache_nway #(
    parameter int S_OFFSET = 5,
    parameter int S_INDEX  = 3,
    parameter int NUM_WAYS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [31:0]                   mem_address,
    input  logic                          mem_read,
    input  logic                          mem_write,
    input  logic [8*(2**S_OFFSET)-1:0]    mem_wdata256,
    output logic [8*(2**S_OFFSET)-1:0]    mem_rdata256,
    output logic                          mem_resp,
    output logic [31:0]                   pmem_address,
    output logic                          pmem_read,
    output logic                          pmem_write,
    output logic [8*(2**S_OFFSET)-1:0]    pmem_wdata,
    input  logic [8*(2**S_OFFSET)-1:0]    pmem_rdata,
    input  logic                          pmem_resp
`ifdef L2_PERF_COUNTERS_EN
    ,
    output logic [31:0]                   hit_count,
    output logic [31:0]                   miss_count
`endif
);

    localparam int LINE_W = 8 * (2 ** S_OFFSET);
    localparam int TAG_W  = 32 - S_OFFSET - S_INDEX;
    localparam int SETS   = 2 ** S_INDEX;
    localparam int WAY_W  = $clog2(NUM_WAYS);

    generate
        if (NUM_WAYS != 2 && NUM_WAYS != 4 && NUM_WAYS != 8) begin : g_bad_ways
            $fatal(1, "l2_cache_nway: NUM_WAYS must be 2, 4 or 8");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, CHECK, WRITEBACK, FILL} state_t;

    state_t state, state_nxt;

    logic [NUM_WAYS-1:0] valid [SETS];
    logic [NUM_WAYS-1:0] dirty [SETS];
    logic [NUM_WAYS-2:0] plru  [SETS];
    logic [TAG_W-1:0]    tag_mem  [NUM_WAYS][SETS];
    logic [LINE_W-1:0]   line_mem [NUM_WAYS][SETS];

    logic [TAG_W-1:0]    req_tag;
    logic [S_INDEX-1:0]  req_index;
    logic                req_write;
    logic [LINE_W-1:0]   req_wdata;
    logic [WAY_W-1:0]    victim_way;

    logic [NUM_WAYS-1:0] hit_vec;
    logic                hit;
    logic [WAY_W-1:0]    hit_way;
    logic                has_invalid;
    logic [WAY_W-1:0]    inv_way;
    logic [WAY_W-1:0]    victim_nxt;
    logic                unused_offset;

    assign unused_offset = ^mem_address[S_OFFSET-1:0];

    // PLRU node bits point toward the subtree holding the next victim; heap-ordered, root first.
    function automatic logic [NUM_WAYS-2:0] plru_touch(input logic [NUM_WAYS-2:0] bits,
                                                       input logic [WAY_W-1:0]    way);
        logic [NUM_WAYS-2:0] b;
        logic [WAY_W-1:0]    w;
        logic                d;
        int                  node;
        b    = bits;
        w    = way;
        node = 0;
        for (int l = 0; l < WAY_W; l++) begin
            d                    = w[WAY_W-1];
            w                    = w << 1;
            b[node[WAY_W-1:0]]   = ~d;
            node                 = 2 * node + 1 + int'(d);
        end
        return b;
    endfunction

    function automatic logic [WAY_W-1:0] plru_victim(input logic [NUM_WAYS-2:0] bits);
        logic [WAY_W-1:0] w;
        logic             d;
        int               node;
        w    = '0;
        node = 0;
        for (int l = 0; l < WAY_W; l++) begin
            d    = bits[node[WAY_W-1:0]];
            w    = w << 1;
            w[0] = d;
            node = 2 * node + 1 + int'(d);
        end
        return w;
    endfunction

    always_comb begin
        hit_vec     = '0;
        hit_way     = '0;
        has_invalid = 1'b0;
        inv_way     = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            hit_vec[w] = valid[req_index][w] && (tag_mem[w][req_index] == req_tag);
            if (hit_vec[w])
                hit_way = w[WAY_W-1:0];
        end
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid[req_index][w]) begin
                has_invalid = 1'b1;
                inv_way     = w[WAY_W-1:0];
            end
        end
        hit        = $onehot(hit_vec);
        victim_nxt = has_invalid ? inv_way : plru_victim(plru[req_index]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (mem_read || mem_write) state_nxt = CHECK;
            CHECK: begin
                if (hit)
                    state_nxt = IDLE;
                else if (valid[req_index][victim_nxt] && dirty[req_index][victim_nxt])
                    state_nxt = WRITEBACK;
                else
                    state_nxt = FILL;
            end
            WRITEBACK: if (pmem_resp) state_nxt = FILL;
            FILL:      if (pmem_resp) state_nxt = CHECK;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_resp     = 1'b0;
        mem_rdata256 = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        case (state)
            CHECK: begin
                if (hit) begin
                    mem_resp = 1'b1;
                    if (!req_write)
                        mem_rdata256 = line_mem[hit_way][req_index];
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_mem[victim_way][req_index], req_index, {S_OFFSET{1'b0}}};
                pmem_wdata   = line_mem[victim_way][req_index];
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {req_tag, req_index, {S_OFFSET{1'b0}}};
            end
            default: ;
        endcase
    end

    // Control state; a simultaneous read+write is latched as a write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                dirty[s] <= '0;
                plru[s]  <= '0;
            end
            req_tag    <= '0;
            req_index  <= '0;
            req_write  <= 1'b0;
            req_wdata  <= '0;
            victim_way <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_read || mem_write) begin
                        req_tag   <= mem_address[31 -: TAG_W];
                        req_index <= mem_address[S_OFFSET +: S_INDEX];
                        req_write <= mem_write;
                        req_wdata <= mem_wdata256;
                    end
                end
                CHECK: begin
                    if (hit) begin
                        plru[req_index] <= plru_touch(plru[req_index], hit_way);
                        if (req_write)
                            dirty[req_index][hit_way] <= 1'b1;
                    end else begin
                        victim_way <= victim_nxt;
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp)
                        dirty[req_index][victim_way] <= 1'b0;
                end
                FILL: begin
                    if (pmem_resp) begin
                        valid[req_index][victim_way] <= 1'b1;
                        dirty[req_index][victim_way] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == CHECK && hit && req_write)
            line_mem[hit_way][req_index] <= req_wdata;
        if (state == FILL && pmem_resp) begin
            line_mem[victim_way][req_index] <= pmem_rdata;
            tag_mem[victim_way][req_index]  <= req_tag;
        end
    end

`ifdef L2_PERF_COUNTERS_EN
    logic recheck;

    // The CHECK that follows a fill is a replay of an already-counted miss.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            recheck    <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (state == IDLE)
                recheck <= 1'b0;
            else if (state == FILL && pmem_resp)
                recheck <= 1'b1;
            if (state == CHECK) begin
                if (hit && !recheck)
                    hit_count <= hit_count + 32'd1;
                else if (!hit)
                    miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule
